// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and datapath width for the ALU issue sequencer.
// Op code values match the ALU select encoding directly.
package alu_pkg;
    localparam int DW = 32;

    typedef enum logic [2:0] {
        OP_NOT = 3'b000,
        OP_AND = 3'b001,
        OP_XOR = 3'b010,
        OP_OR  = 3'b011,
        OP_DEC = 3'b100,
        OP_ADD = 3'b101,
        OP_SUB = 3'b110,
        OP_INC = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;
endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one sync write port, r0 hardwired to zero.
// Latency: reads combinational, writes visible the cycle after the write edge.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);
    logic [DW-1:0] rf_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : rf_q[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : rf_q[rb_addr];
endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer wrapping a combinational ALU into a clocked execute stage.
// Latency: accept -> writeback edge one cycle later; one op per 3 cycles, in_ready low in EXEC/WB.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_inp1,
    output logic [DW-1:0] alu_inp2,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_outp,
    input  logic          alu_overflow,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [AW-1:0] res_rd,
    output logic          res_ovf,
    output logic          ovf_sticky
);
    state_e        state_q;
    logic [DW-1:0] inp1_q, inp2_q, res_data_q;
    logic [2:0]    sel_q;
    logic [AW-1:0] rd_q, res_rd_q;
    logic          res_valid_q, res_ovf_q, sticky_q;

    logic [DW-1:0] rs_data, rt_data;
    logic          accept, ld_we, wb_we, wb_ovf;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    assign in_ready = (state_q == IDLE) && !ld_valid;
    assign accept   = in_valid && in_ready;
    assign ld_we    = (state_q == IDLE) && ld_valid;
    assign wb_we    = (state_q == EXEC);
    // Overflow only has meaning for add; the ALU may flag it on other ops.
    assign wb_ovf   = (sel_q == OP_ADD) && alu_overflow;

    // Load and writeback never coincide: one is IDLE-only, the other EXEC-only.
    always_comb begin
        rf_we = ld_we || wb_we;
        rf_wa = ld_addr;
        rf_wd = ld_data;
        if (wb_we) begin
            rf_wa = rd_q;
            rf_wd = alu_outp;
        end
    end

    alu_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (in_rs),
        .ra_data (rs_data),
        .rb_addr (in_rt),
        .rb_data (rt_data),
        .wr_en   (rf_we),
        .wr_addr (rf_wa),
        .wr_data (rf_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            inp1_q      <= '0;
            inp2_q      <= '0;
            sel_q       <= '0;
            rd_q        <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            res_valid_q <= (state_q == EXEC);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= EXEC;
                        inp1_q  <= rs_data;
                        inp2_q  <= rt_data;
                        sel_q   <= in_op;
                        rd_q    <= in_rd;
                    end
                end
                EXEC: begin
                    state_q    <= WB;
                    res_data_q <= alu_outp;
                    res_rd_q   <= rd_q;
                    res_ovf_q  <= wb_ovf;
                    if (wb_ovf) sticky_q <= 1'b1;
                end
                WB:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_inp1   = inp1_q;
    assign alu_inp2   = inp2_q;
    assign alu_sel    = sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_rd     = res_rd_q;
    assign res_ovf    = res_ovf_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU beside the DUT, scoreboard of expected writebacks.
module tb_alu_issue_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  rd;
        logic        ovf;
        logic        sticky;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_op, in_rs, in_rt, in_rd;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_inp1, alu_inp2, alu_outp;
    logic [2:0]  alu_sel;
    logic        alu_overflow;
    logic        res_valid, res_ovf, ovf_sticky;
    logic [31:0] res_data;
    logic [2:0]  res_rd;

    int errors = 0;
    int checks = 0;
    exp_t sbq[$];
    logic [31:0] mrf [8];
    logic msticky;

    always #5 clk = ~clk;

    alu_issue_seq #(.NREG(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_sel(alu_sel),
        .alu_outp(alu_outp), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .res_ovf(res_ovf), .ovf_sticky(ovf_sticky)
    );

    // Returns {overflow, result}; overflow flagged for signed add/sub/inc/dec.
    function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            OP_NOT: r = ~a;
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_DEC: begin r = a - 32'd1; v = (a == 32'h8000_0000); end
            OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            default: begin r = a + 32'd1; v = (a == 32'h7FFF_FFFF); end
        endcase
        return {v, r};
    endfunction

    always_comb {alu_overflow, alu_outp} = alu_fn(alu_sel, alu_inp1, alu_inp2);

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: res_valid with data=%h rd=%0d, required no writeback", res_data, res_rd);
            end else begin
                e = sbq.pop_front();
                if ({res_data, res_rd, res_ovf, ovf_sticky} !== {e.data, e.rd, e.ovf, e.sticky}) begin
                    errors++;
                    $display("FAIL sb_result: got data=%h rd=%0d ovf=%b sticky=%b, required data=%h rd=%0d ovf=%b sticky=%b",
                             res_data, res_rd, res_ovf, ovf_sticky, e.data, e.rd, e.ovf, e.sticky);
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        logic [32:0] r;
        logic        o;
        r = alu_fn(op, mrf[rs], mrf[rt]);
        o = (op == OP_ADD) ? r[32] : 1'b0;
        if (o) msticky = 1'b1;
        sbq.push_back('{data: r[31:0], rd: rd, ovf: o, sticky: msticky});
        if (rd != 3'd0) mrf[rd] = r[31:0];
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0;
        if (a != 3'd0) mrf[a] = d;
    endtask

    // Starts and ends at a negedge in IDLE; checks res_valid lands 2 cycles after accept.
    task automatic issue(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        int n, lat;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        push_exp(op, rs, rt, rd);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (res_valid) begin lat = i; break; end
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL issue_latency op=%0d: got %0d cycles (0 = none), required 2", op, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        msticky = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({alu_inp1, alu_inp2, alu_sel, res_data, res_rd, res_valid, res_ovf, ovf_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got inp1=%h inp2=%h sel=%0d data=%h rd=%0d vld=%b ovf=%b sticky=%b, required all 0",
                     alu_inp1, alu_inp2, alu_sel, res_data, res_rd, res_valid, res_ovf, ovf_sticky);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_add;
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3);
        checks++;
        if ({res_data, res_rd, res_ovf} !== {32'd8, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL add_basic: got data=%0d rd=%0d ovf=%b, required 8 3 0", res_data, res_rd, res_ovf);
        end
        issue(OP_ADD, 3'd3, 3'd0, 3'd4);
        checks++;
        if (res_data !== 32'd8) begin errors++; $display("FAIL add_raw: got %0d, required 8", res_data); end
    endtask

    task automatic test_overflow;
        load(3'd1, 32'h7FFF_FFFF);
        load(3'd2, 32'd1);
        issue(OP_INC, 3'd1, 3'd0, 3'd5);
        checks++;
        if ({res_data, res_ovf, ovf_sticky} !== {32'h8000_0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL inc_ovf_masked: got data=%h ovf=%b sticky=%b, required 80000000 0 0", res_data, res_ovf, ovf_sticky);
        end
        issue(OP_ADD, 3'd1, 3'd2, 3'd3);
        checks++;
        if ({res_data, res_ovf, ovf_sticky} !== {32'h8000_0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got data=%h ovf=%b sticky=%b, required 80000000 1 1", res_data, res_ovf, ovf_sticky);
        end
        issue(OP_SUB, 3'd2, 3'd2, 3'd4);
        checks++;
        if ({res_data, res_ovf, ovf_sticky} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_sticky: got data=%h ovf=%b sticky=%b, required 0 0 1", res_data, res_ovf, ovf_sticky);
        end
    endtask

    task automatic test_r0_dest;
        load(3'd1, 32'd9);
        issue(OP_INC, 3'd1, 3'd0, 3'd0);
        checks++;
        if ({res_data, res_rd} !== {32'd10, 3'd0}) begin
            errors++;
            $display("FAIL r0_inc: got data=%0d rd=%0d, required 10 0", res_data, res_rd);
        end
        issue(OP_OR, 3'd0, 3'd0, 3'd6);
        checks++;
        if (res_data !== 32'd0) begin errors++; $display("FAIL r0_read: got %h, required 0", res_data); end
    endtask

    logic [2:0]  lop [5] = '{OP_NOT, OP_AND, OP_XOR, OP_OR, OP_DEC};
    logic [31:0] lexp[5] = '{32'h0F0F0F0F, 32'h00F000F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'hF0F0F0EF};

    task automatic test_logic;
        load(3'd1, 32'hF0F0_F0F0);
        load(3'd2, 32'h0FF0_0FF0);
        for (int i = 0; i < 5; i++) begin
            issue(lop[i], 3'd1, 3'd2, 3'd3);
            checks++;
            if (res_data !== lexp[i]) begin
                errors++;
                $display("FAIL logic_op%0d: got %h, required %h", lop[i], res_data, lexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc [$];
        in_valid = 1'b1; in_op = OP_XOR; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd3;
        for (int c = 0; c < 12; c++) begin
            if (in_ready) begin
                acc.push_back(c);
                push_exp(OP_XOR, 3'd1, 3'd2, 3'd3);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d accepts, required 4", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin
                errors++;
                $display("FAIL b2b_gap%0d: got %0d cycles, required 3", i, acc[i] - acc[i-1]);
            end
        end
        repeat (3) @(negedge clk);
        // Load and issue requested together: load wins, no accept.
        in_valid = 1'b1; in_op = OP_ADD; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd6;
        ld_valid = 1'b1; ld_addr = 3'd7; ld_data = 32'hA5A5_5A5A;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_prio_ready: got %b, required 0", in_ready); end
        @(negedge clk);
        ld_valid = 1'b0; in_valid = 1'b0;
        mrf[7] = 32'hA5A5_5A5A;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_prio_noaccept: in_ready got %b, required 1", in_ready); end
        issue(OP_AND, 3'd7, 3'd7, 3'd3);
        checks++;
        if (res_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL ld_prio_data: got %h, required a5a55a5a", res_data); end
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        load(3'd1, 32'd4);
        load(3'd2, 32'd6);
        in_valid = 1'b1; in_op = OP_ADD; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if ({alu_inp1, alu_inp2, alu_sel} !== {32'd4, 32'd6, OP_ADD}) begin
            errors++;
            $display("FAIL exec_drive: got inp1=%0d inp2=%0d sel=%0d, required 4 6 5", alu_inp1, alu_inp2, alu_sel);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        msticky = 1'b0;
        sbq.delete();
        #1;
        checks++;
        if ({alu_inp1, alu_inp2, alu_sel, res_data, res_rd, res_valid, res_ovf, ovf_sticky} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got inp1=%h inp2=%h sel=%0d data=%h rd=%0d vld=%b ovf=%b sticky=%b, required all 0",
                     alu_inp1, alu_inp2, alu_sel, res_data, res_rd, res_valid, res_ovf, ovf_sticky);
        end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (res_valid) seen = 1'b1; end
        rst_n = 1'b1;
        @(negedge clk);
        if (res_valid) seen = 1'b1;
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_res_valid: got res_valid=1, required 0"); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b, required 1", in_ready); end
        issue(OP_OR, 3'd5, 3'd0, 3'd6);
        checks++;
        if (res_data !== 32'd0) begin errors++; $display("FAIL abort_r5_cleared: got %h, required 0", res_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_r0_dest();
        test_logic();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain: %0d writebacks missing, required 0", sbq.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Issue/writeback sequencer that sits directly upstream of the 32-bit ALU. It holds an 8-entry register file, accepts one operation per handshake, and drives the ALU's operand and select inputs from registered values. It then captures the ALU result and overflow flag and writes the result back to the destination register. It converts the purely combinational ALU into a clocked execute stage with a valid/ready front end and a one-cycle result strobe.

## Interface
- NREG, 8: number of registers; register 0 reads as zero.
- AW, 3: register index width, equal to $clog2(NREG).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept an operation.
- in_op  in  3  ALU select code: 000 not, 001 and, 010 xor, 011 or, 100 dec, 101 add, 110 sub, 111 inc.
- in_rs, in_rt, in_rd  in  AW each  source 1, source 2, and destination indices.
- ld_valid  in  1  direct register load request.
- ld_addr  in  AW  register index for the load.
- ld_data  in  32  load value.
- alu_inp1, alu_inp2  out  32 each  ALU operands.
- alu_sel  out  3  ALU select.
- alu_outp  in  32  ALU result.
- alu_overflow  in  1  ALU overflow output.
- res_valid  out  1  one-cycle strobe: writeback occurred.
- res_data  out  32  written-back value.
- res_rd  out  AW  written-back register index.
- res_ovf  out  1  overflow of this op; meaningful for add only, 0 for every other op.
- ovf_sticky  out  1  OR of all res_ovf since reset.

## Operation
- FSM states and transitions:
  - IDLE -> EXEC on accept.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- in_ready = (state == IDLE) && !ld_valid. Accept occurs when in_valid && in_ready.
- On accept:
  - latch op and rd.
  - latch opA = RF[rs] and opB = RF[rt]; index 0 yields 32'h0.
- ALU drive:
  - In EXEC, alu_inp1 = opA, alu_inp2 = opB, alu_sel = op.
  - In all other states, operands hold their last values and alu_sel holds.
  - Unary ops (000, 100, 111) still drive opB; the ALU ignores it.
- At the EXEC -> WB edge:
  - RF[rd] <= alu_outp, unless rd == 0, in which case the write is discarded.
  - res_data <= alu_outp and res_rd <= rd.
  - res_ovf <= alu_overflow if op == 101, else 0.
- In WB: res_valid = 1. res_data, res_rd, and res_ovf hold until the next writeback.
- ovf_sticky sets at the EXEC -> WB edge when the captured overflow is 1. It is cleared only by reset.
- Load port:
  - ld_valid is honoured only in IDLE: RF[ld_addr] <= ld_data, with writes to 0 ignored.
  - In other states ld_valid is dropped silently; the driver must wait for in_ready.
  - Load takes priority over an issue in the same cycle, which is enforced by in_ready.
- Arithmetic is 32-bit wrap-around, entirely performed by the ALU. The sequencer performs no arithmetic.

## Timing
- Reset values: state IDLE; all RF entries 0; alu_inp1, alu_inp2, alu_sel, res_data, res_rd all 0; res_valid, res_ovf, ovf_sticky all 0. in_ready = 1 after reset when ld_valid = 0.
- Latency: accept edge E0, ALU evaluated in cycle E0+1, writeback at edge E1 = E0+1, res_valid high in cycle E1+1.
- Throughput: one op per 3 cycles. in_ready is low during EXEC and WB.
- RAW hazard: an op accepted in the IDLE after WB reads the updated register. No forwarding is needed.
- An operation with rs == rd reads the old value; the new value appears after writeback.
- rst_n asserted mid-operation: abort immediately, with no writeback and no res_valid. The RF returns to zero.

## Structure
- Shared package alu_pkg:
  - op codes OP_NOT=3'b000 through OP_INC=3'b111.
  - state enum {IDLE, EXEC, WB}.
  - DW=32.
- One sub-module is natural: alu_regfile, with two async read ports, one sync write port, and r0 hardwired to zero. The issue and load writes are muxed into its single write port.
- The ALU is instantiated alongside this block at the top level, not inside it.

## Test plan
- Reset, then load r1=5 and r2=3, then issue add r3=r1+r2 -> res_valid exactly 2 cycles after the accept edge; res_data=8, res_rd=3, res_ovf=0; a later add r4=r3+r0 gives 8.
- Load r1=32'h7FFFFFFF and r2=1, add r3 -> res_data=32'h80000000, res_ovf=1, ovf_sticky=1. A following sub r4=r2-r2 gives 0, res_ovf=0, and ovf_sticky stays 1.
- Destination r0: inc r0=r1 where r1=9 -> res_data=10 and res_rd=0; a subsequent read of r0 gives 0.
- Unary and logic ops with r1=32'hF0F0F0F0 and r2=32'h0FF00FF0:
  - not -> 32'h0F0F0F0F
  - and -> 32'h00F000F0
  - xor -> 32'hFF00FF00
  - or -> 32'hFFF0FFF0
  - dec -> 32'hF0F0F0EF
- in_valid held high continuously -> accepts exactly every 3 cycles. With ld_valid=1 in IDLE, in_ready=0, the load is applied, and no accept occurs that cycle.
- Assert rst_n low during EXEC of add r5 -> no res_valid; r5=0 and all outputs are at reset values; in_ready=1 one cycle after deassertion.
